// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
//
// Purpose:
//   Multiplexed driver for a 4-digit, 7-segment display with active-low
//   segment and digit-select lines. A 16-bit value is shown as four hex
//   digits. One digit is lit per time slot. Each slot begins with a
//   blanking gap so that the previous digit's pattern does not ghost onto
//   the next one while the select lines settle.
//
//   The displayed value, decimal points and digit enables are captured into
//   shadow registers once per frame, on the last cycle of digit 3. The scan
//   therefore never shows a mix of old and new data within one frame.
//
// Parameters:
//   SCAN_DIV      clk cycles per digit slot (>= 2)
//   BLANK_CYCLES  cycles at the start of each slot with every digit dark
//                 (< SCAN_DIV)
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset_n      in   1   synchronous, active-low reset
//   value        in  16   hex value; value[3:0] is digit 0 (rightmost)
//   dp_in        in   4   decimal point per digit, 1 = lit
//   digit_en     in   4   per-digit enable, 0 = digit kept dark
//   io_seg       out  8   segment drive, active-low, {dp,g,f,e,d,c,b,a}
//   io_sel       out  4   digit select, active-low, bit i = digit i
//   frame_start  out  1   one-cycle pulse in the first cycle of each frame
//
// Timing:
//   io_seg / io_sel are registered. The pins in cycle t reflect the slot
//   position and shadow contents of cycle t-1. frame_start is high exactly
//   in the cycle where the digit index is 0 and the prescaler is 0.
// -----------------------------------------------------------------------------
module seven_seg_scan #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [7:0]  io_seg,
    output logic [3:0]  io_sel,
    output logic        frame_start
);

    // Prescaler width. SCAN_DIV >= 2 guarantees at least one bit.
    localparam int PW = $clog2(SCAN_DIV);

    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);

    // -------------------------------------------------------------------------
    // Hex digit to active-high {g,f,e,d,c,b,a} segment pattern.
    // -------------------------------------------------------------------------
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    // -------------------------------------------------------------------------
    // Scan position: prescaler within the slot, digit index within the frame
    // -------------------------------------------------------------------------
    logic [PW-1:0] r_p;
    logic [1:0]    r_d;

    // Frame-stable copies of the inputs
    logic [15:0]   r_shadow_value;
    logic [3:0]    r_shadow_dp;
    logic [3:0]    r_shadow_en;

    // Registered pin drivers
    logic [7:0]    r_seg;
    logic [3:0]    r_sel;
    logic          r_frame_start;

    // Combinational helpers
    logic          w_slot_end;
    logic          w_frame_end;
    logic          w_blank;
    logic          w_lit;
    logic [3:0]    w_nibble;
    logic [6:0]    w_hex;
    logic [7:0]    w_seg_next;
    logic [3:0]    w_sel_next;

    assign w_slot_end  = (r_p == P_LAST);
    assign w_frame_end = w_slot_end && (r_d == 2'd3);
    assign w_blank     = (r_p < P_BLANK);

    // -------------------------------------------------------------------------
    // Prescaler and digit index
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_p <= '0;
            r_d <= 2'd0;
        end else if (w_slot_end) begin
            r_p <= '0;
            r_d <= r_d + 2'd1;  // 3 -> 0 by natural 2-bit wrap
        end else begin
            r_p <= r_p + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Frame latch. Capturing on the last cycle of digit 3 means the new data
    // is first used in the cycle where the scan returns to digit 0, slot
    // position 0, which is also the cycle frame_start is high.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shadow_value <= 16'h0000;
            r_shadow_dp    <= 4'h0;
            r_shadow_en    <= 4'h0;
            r_frame_start  <= 1'b0;
        end else begin
            r_frame_start <= w_frame_end;
            if (w_frame_end) begin
                r_shadow_value <= value;
                r_shadow_dp    <= dp_in;
                r_shadow_en    <= digit_en;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next pin values from the current scan position and shadow data
    // -------------------------------------------------------------------------
    always_comb begin
        case (r_d)
            2'd0:    w_nibble = r_shadow_value[3:0];
            2'd1:    w_nibble = r_shadow_value[7:4];
            2'd2:    w_nibble = r_shadow_value[11:8];
            default: w_nibble = r_shadow_value[15:12];
        endcase
    end

    assign w_hex = hex7(w_nibble);
    assign w_lit = !w_blank && r_shadow_en[r_d];

    always_comb begin
        w_sel_next = 4'hF;
        w_seg_next = 8'hFF;
        if (w_lit) begin
            // Exactly one select line goes low, so two digits never light
            // together.
            w_sel_next = ~(4'b0001 << r_d);
            w_seg_next = ~{r_shadow_dp[r_d], w_hex};
        end
    end

    // -------------------------------------------------------------------------
    // Output registers. Segments and select share one register stage, so
    // both always change on the same edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_seg <= 8'hFF;
            r_sel <= 4'hF;
        end else begin
            r_seg <= w_seg_next;
            r_sel <= w_sel_next;
        end
    end

    assign io_seg      = r_seg;
    assign io_sel      = r_sel;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan
//
// Directed testbench for seven_seg_scan with SCAN_DIV=8, BLANK_CYCLES=2.
//
// Frame timing used throughout:
//   c0 = the cycle in which frame_start is high (scan at digit 0, p=0).
//   In cycle c0+k (k = 1..32) the pins reflect digit d=(k-1)/8 and
//   prescaler p=(k-1)%8 of the frame that began at c0. Cycles with p<2 are
//   blank, and cycles with p>=2 show the digit. Cycle c0+32 is the next
//   frame_start.
// Outputs are sampled on the falling clock edge. Inputs change there too.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  digit_en = 4'h0;
    logic [7:0]  io_seg;
    logic [3:0]  io_sel;
    logic        frame_start;

    int checks = 0;
    int failures = 0;

    // Active-low segment codes (dp off) for hex digits 0..F
    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    // Active-low select for digits 0..3
    logic [3:0] sel_tbl [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
    // value=1234: digits 0..3 show 4,3,2,1
    logic [7:0] exp_1234 [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    // value=ABCD: digits 0..3 show D,C,B,A
    logic [7:0] exp_abcd [4] = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    logic [15:0] sweep_vals [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};

    seven_seg_scan #(
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .value       (value),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .io_seg      (io_seg),
        .io_sel      (io_sel),
        .frame_start (frame_start)
    );

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to the next falling edge at which frame_start is high.
    task automatic wait_frame_start();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL wait_frame_start: frame_start=%b, required a pulse within 40 cycles", frame_start);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset_n  = 1'b0;
        value    = 16'h1234;
        digit_en = 4'hF;
        dp_in    = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (io_seg !== 8'hFF) begin
                failures++;
                $display("FAIL reset_seg cyc=%0d: got %h, required ff", i, io_seg);
            end
            checks++;
            if (io_sel !== 4'hF) begin
                failures++;
                $display("FAIL reset_sel cyc=%0d: got %h, required f", i, io_sel);
            end
            checks++;
            if (frame_start !== 1'b0) begin
                failures++;
                $display("FAIL reset_fs cyc=%0d: got %b, required 0", i, frame_start);
            end
        end
        reset_n = 1'b1;
        // First frame: shadow enables are 0, so everything stays dark, and
        // the first pulse comes 32 cycles after release.
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            checks++;
            if (frame_start !== (i == 32)) begin
                failures++;
                $display("FAIL first_frame_fs cyc=%0d: got %b, required %b", i, frame_start, (i == 32));
            end
            checks++;
            if (io_sel !== 4'hF || io_seg !== 8'hFF) begin
                failures++;
                $display("FAIL first_frame_dark cyc=%0d: got sel=%h seg=%h, required f/ff", i, io_sel, io_seg);
            end
        end
    endtask

    task automatic test_decode();
        logic [3:0] exp_sel;
        logic [7:0] exp_seg;
        value    = 16'h1234;
        digit_en = 4'hF;
        dp_in    = 4'h0;
        wait_frame_start();
        for (int k = 1; k <= 32; k++) begin
            int d;
            int p;
            @(negedge clk);
            d = (k - 1) / 8;
            p = (k - 1) % 8;
            exp_sel = (p < 2) ? 4'hF  : sel_tbl[d];
            exp_seg = (p < 2) ? 8'hFF : exp_1234[d];
            checks++;
            if (io_sel !== exp_sel) begin
                failures++;
                $display("FAIL decode_sel k=%0d: got %h, required %h", k, io_sel, exp_sel);
            end
            checks++;
            if (io_seg !== exp_seg) begin
                failures++;
                $display("FAIL decode_seg k=%0d: got %h, required %h", k, io_seg, exp_seg);
            end
        end
    endtask

    task automatic test_hex_sweep();
        digit_en = 4'hF;
        dp_in    = 4'h0;
        for (int v = 0; v < 4; v++) begin
            value = sweep_vals[v];
            wait_frame_start();
            for (int k = 1; k <= 32; k++) begin
                int d;
                int p;
                @(negedge clk);
                d = (k - 1) / 8;
                p = (k - 1) % 8;
                if (p == 4) begin
                    checks++;
                    if (io_seg !== seg_tbl[4*v + d] || io_sel !== sel_tbl[d]) begin
                        failures++;
                        $display("FAIL hex_sweep nibble=%h: got sel=%h seg=%h, required sel=%h seg=%h",
                                 4*v + d, io_sel, io_seg, sel_tbl[d], seg_tbl[4*v + d]);
                    end
                end
            end
        end
    endtask

    task automatic test_blanking();
        value    = 16'h5A5A;
        digit_en = 4'hF;
        dp_in    = 4'hF;
        wait_frame_start();
        for (int f = 0; f < 2; f++) begin
            int n_blank;
            int n_lit;
            n_blank = 0;
            n_lit   = 0;
            for (int k = 1; k <= 32; k++) begin
                int d;
                int p;
                @(negedge clk);
                d = (k - 1) / 8;
                p = (k - 1) % 8;
                if (p < 2 && io_sel === 4'hF && io_seg === 8'hFF) n_blank++;
                if (p >= 2 && io_sel === sel_tbl[d]) n_lit++;
                checks++;
                if (frame_start !== (k == 32)) begin
                    failures++;
                    $display("FAIL blank_fs_spacing frame=%0d k=%0d: got %b, required %b",
                             f, k, frame_start, (k == 32));
                end
                if (p == 7) begin
                    checks++;
                    if (n_blank != 2 || n_lit != 6) begin
                        failures++;
                        $display("FAIL blank_slot frame=%0d digit=%0d: got blank=%0d lit=%0d, required 2/6",
                                 f, d, n_blank, n_lit);
                    end
                    n_blank = 0;
                    n_lit   = 0;
                end
            end
        end
    endtask

    task automatic test_tearing();
        value    = 16'h1234;
        digit_en = 4'hF;
        dp_in    = 4'h0;
        wait_frame_start();
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 19) value = 16'hABCD;
            if (k == 20) begin
                checks++;
                if (io_sel !== 4'hB || io_seg !== 8'hA4) begin
                    failures++;
                    $display("FAIL tear_digit2: got sel=%h seg=%h, required b/a4", io_sel, io_seg);
                end
            end
            if (k == 28) begin
                checks++;
                if (io_sel !== 4'h7 || io_seg !== 8'hF9) begin
                    failures++;
                    $display("FAIL tear_digit3: got sel=%h seg=%h, required 7/f9", io_sel, io_seg);
                end
            end
        end
        // Now at the next frame_start; ABCD was latched on the edge before.
        for (int k = 1; k <= 32; k++) begin
            int d;
            int p;
            @(negedge clk);
            d = (k - 1) / 8;
            p = (k - 1) % 8;
            if (p == 3) begin
                checks++;
                if (io_sel !== sel_tbl[d] || io_seg !== exp_abcd[d]) begin
                    failures++;
                    $display("FAIL tear_next_frame digit=%0d: got sel=%h seg=%h, required %h/%h",
                             d, io_sel, io_seg, sel_tbl[d], exp_abcd[d]);
                end
            end
        end
    endtask

    task automatic test_enables_dp();
        logic [3:0] exp_sel;
        logic [7:0] exp_seg;
        value    = 16'h1234;
        digit_en = 4'b0011;
        dp_in    = 4'b0001;
        wait_frame_start();
        for (int k = 1; k <= 32; k++) begin
            int d;
            int p;
            @(negedge clk);
            d = (k - 1) / 8;
            p = (k - 1) % 8;
            exp_sel = 4'hF;
            exp_seg = 8'hFF;
            if (p >= 2 && d == 0) begin
                exp_sel = 4'hE;
                exp_seg = 8'h19;  // digit "4" with dp lit (bit 7 low)
            end else if (p >= 2 && d == 1) begin
                exp_sel = 4'hD;
                exp_seg = 8'hB0;  // digit "3", dp dark (bit 7 high)
            end
            checks++;
            if (io_sel !== exp_sel || io_seg !== exp_seg) begin
                failures++;
                $display("FAIL en_dp k=%0d: got sel=%h seg=%h, required %h/%h",
                         k, io_sel, io_seg, exp_sel, exp_seg);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        value    = 16'h1234;
        digit_en = 4'hF;
        dp_in    = 4'h0;
        wait_frame_start();
        // After 21 cycles the scan sits at digit 2, p=5.
        repeat (21) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (io_seg !== 8'hFF || io_sel !== 4'hF || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: got seg=%h sel=%h fs=%b, required ff/f/0",
                     io_seg, io_sel, frame_start);
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            checks++;
            if (frame_start !== (i == 32)) begin
                failures++;
                $display("FAIL midreset_fs cyc=%0d: got %b, required %b", i, frame_start, (i == 32));
            end
            checks++;
            if (io_sel !== 4'hF || io_seg !== 8'hFF) begin
                failures++;
                $display("FAIL midreset_dark cyc=%0d: got sel=%h seg=%h, required f/ff", i, io_sel, io_seg);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (io_sel !== 4'hE || io_seg !== 8'h99) begin
            failures++;
            $display("FAIL midreset_relit: got sel=%h seg=%h, required e/99", io_sel, io_seg);
        end
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        test_reset();
        test_decode();
        test_hex_sweep();
        test_blanking();
        test_tearing();
        test_enables_dp();
        test_mid_frame_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
